// File: rtl/psm_seq.sv
// Programmable operation sequencer: captures two operands on a start edge, then
// steps through a runtime-writable table of (duration, ALU function) entries.
module psm_seq #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_OPS = 3,
  parameter  int CNT_W   = 5,
  localparam int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din1,
  input  logic [WIDTH-1:0]   din2,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [CNT_W-1:0]   cfg_time,
  input  logic [2:0]         cfg_func,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [NUM_OPS-1:0] op_onehot,
  output logic [IDX_W-1:0]   op_idx,
  output logic [WIDTH-1:0]   dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic             start_q;
  logic             start_edge;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] op_q, op_d;
  logic             capture;
  logic             cfg_accept;
  logic             last_cycle;

  logic             first_valid, next_valid;
  logic [IDX_W-1:0] first_idx, next_idx;

  logic [CNT_W-1:0] time_tbl [NUM_OPS];
  logic [2:0]       func_tbl [NUM_OPS];

  function automatic logic [CNT_W-1:0] reset_time(input int i);
    case (i)
      0:       reset_time = CNT_W'(3);
      1:       reset_time = CNT_W'(1);
      2:       reset_time = CNT_W'(8);
      default: reset_time = CNT_W'(1);
    endcase
  endfunction

  function automatic logic [2:0] reset_func(input int i);
    case (i)
      0:       reset_func = 3'd0;
      1:       reset_func = 3'd1;
      2:       reset_func = 3'd2;
      default: reset_func = 3'd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] f,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (f)
      3'd0:    alu = a | b;
      3'd1:    alu = a ^ b;
      3'd2:    alu = ~(~a & b);
      3'd3:    alu = a & b;
      3'd4:    alu = a + b;
      3'd5:    alu = a - b;
      3'd6:    alu = ~a;
      default: alu = b;
    endcase
  endfunction

  assign start_edge = start & ~start_q;
  assign last_cycle = (cnt_q == time_tbl[op_q] - CNT_W'(1));
  assign cfg_accept = cfg_we && (state == S_IDLE) && !start_edge &&
                      (int'(cfg_idx) < NUM_OPS);

  // Scanning downward leaves the lowest qualifying index in each result.
  always_comb begin
    first_valid = 1'b0;
    first_idx   = '0;
    next_valid  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (time_tbl[i] != '0) begin
        first_valid = 1'b1;
        first_idx   = IDX_W'(i);
        if (i > int'(op_q)) begin
          next_valid = 1'b1;
          next_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    op_d    = op_q;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          capture = 1'b1;
          cnt_d   = '0;
          if (first_valid) begin
            state_d = S_RUN;
            op_d    = first_idx;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          op_d    = '0;
        end else if (last_cycle) begin
          cnt_d = '0;
          if (next_valid) begin
            op_d = next_idx;
          end else begin
            state_d = S_DONE;
            op_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state   <= state_d;
      start_q <= start;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      if (capture) begin
        a_q <= din1;
        b_q <= din2;
      end
    end
  end

  // Table only changes while idle, so a run always sees a stable program.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        time_tbl[i] <= reset_time(i);
        func_tbl[i] <= reset_func(i);
      end
    end else if (cfg_accept) begin
      time_tbl[cfg_idx] <= cfg_time;
      func_tbl[cfg_idx] <= cfg_func;
    end
  end

  always_comb begin
    ready     = (state == S_IDLE);
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    op_onehot = '0;
    op_idx    = '0;
    dout      = '0;
    if (state == S_RUN) begin
      op_onehot[op_q] = 1'b1;
      op_idx          = op_q;
      dout            = alu(func_tbl[op_q], a_q, b_q);
    end
  end

endmodule

// File: tb/tb_psm_seq.sv
// Scoreboard bench for psm_seq: each scenario queues per-cycle expected outputs
// from a reference table model and compares them as the DUT steps.
module tb_psm_seq;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 3;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   din1, din2;
  logic               start, abort, cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [CNT_W-1:0]   cfg_time;
  logic [2:0]         cfg_func;
  logic               ready, busy, done;
  logic [NUM_OPS-1:0] op_onehot;
  logic [IDX_W-1:0]   op_idx;
  logic [WIDTH-1:0]   dout;

  always #5 clk = ~clk;

  psm_seq #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din1(din1), .din2(din2), .start(start),
    .abort(abort), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_time(cfg_time),
    .cfg_func(cfg_func), .ready(ready), .busy(busy), .done(done),
    .op_onehot(op_onehot), .op_idx(op_idx), .dout(dout)
  );

  typedef struct packed {
    logic               ready;
    logic               busy;
    logic               done;
    logic [NUM_OPS-1:0] oh;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   dout;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   checks = 0;
  int   errors = 0;

  logic [CNT_W-1:0] m_time [NUM_OPS];
  logic [2:0]       m_func [NUM_OPS];

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (f)
      3'd0: r = a | b;
      3'd1: r = a ^ b;
      3'd2: r = a | ~b;
      3'd3: r = a & b;
      3'd4: r = WIDTH'(a + b);
      3'd5: r = WIDTH'(a + ~b + 1);
      3'd6: r = a ^ {WIDTH{1'b1}};
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic obs_t mk(input logic r, input logic bz, input logic d,
                              input logic [NUM_OPS-1:0] oh,
                              input logic [IDX_W-1:0] idx,
                              input logic [WIDTH-1:0] dv);
    return {r, bz, d, oh, idx, dv};
  endfunction

  task automatic model_default();
    m_time[0] = 5'd3; m_time[1] = 5'd1; m_time[2] = 5'd8;
    m_func[0] = 3'd0; m_func[1] = 3'd1; m_func[2] = 3'd2;
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, '0));
  endtask

  task automatic push_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = 0; i < NUM_OPS; i++)
      for (int k = 0; k < int'(m_time[i]); k++)
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, NUM_OPS'(1) << i, IDX_W'(i),
                           ref_alu(m_func[i], a, b)));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0, '0));
  endtask

  task automatic write_cfg(input int idx, input int t, input int f);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_time = CNT_W'(t); cfg_func = 3'(f);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    din1 = a; din2 = b; start = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_default();
  endtask

  task automatic test_reset();
    int k = 0;
    repeat (2) @(posedge clk);
    model_default();
    push_idle(3);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset sample %0d: got %h expected %h", k, o, e);
      end
      rst = 1'b0;
    end
  endtask

  task automatic test_default_run();
    int k = 0;
    pulse_start(8'h5A, 8'h3C);
    repeat (3) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b001, 2'd0, 8'h7E));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, 8'h66));
    repeat (8) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b100, 2'd2, 8'hDB));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 8'h00));
    push_idle(1);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL default_run sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_program();
    int k = 0;
    write_cfg(1, 0, 0); m_time[1] = 5'd0; m_func[1] = 3'd0;
    write_cfg(2, 2, 4); m_time[2] = 5'd2; m_func[2] = 3'd4;
    write_cfg(3, 9, 7);
    pulse_start(8'hF0, 8'h20);
    push_run(8'hF0, 8'h20);
    push_idle(1);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL program sample %0d: got %h expected %h", k, o, e);
      end
    end
    write_cfg(0, 1, 3); m_time[0] = 5'd1; m_func[0] = 3'd3;
    write_cfg(1, 1, 5); m_time[1] = 5'd1; m_func[1] = 3'd5;
    write_cfg(2, 1, 7); m_time[2] = 5'd1; m_func[2] = 3'd7;
    pulse_start(8'h35, 8'h6C);
    push_run(8'h35, 8'h6C);
    push_idle(1);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL program_funcs sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_all_zero();
    int k = 0;
    for (int i = 0; i < NUM_OPS; i++) begin
      write_cfg(i, 0, 0);
      m_time[i] = 5'd0; m_func[i] = 3'd0;
    end
    pulse_start(8'h77, 8'h11);
    push_run(8'h77, 8'h11);
    push_idle(2);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL all_zero sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_abort();
    int k = 0;
    pulse_start(8'h11, 8'h22);
    repeat (3) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b001, 2'd0, ref_alu(m_func[0], 8'h11, 8'h22)));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b010, 2'd1, ref_alu(m_func[1], 8'h11, 8'h22)));
    repeat (2) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b100, 2'd2, ref_alu(m_func[2], 8'h11, 8'h22)));
    push_idle(3);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL abort sample %0d: got %h expected %h", k, o, e);
      end
      abort = (k == 6);
    end
    pulse_start(8'h0F, 8'hF0);
    push_run(8'h0F, 8'hF0);
    push_idle(1);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL abort_restart sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    pulse_start(8'h33, 8'h55);
    push_run(8'h33, 8'h55);
    push_idle(3);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back sample %0d: got %h expected %h", k, o, e);
      end
      start = (k >= 13);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    din1 = 8'h5A; din2 = 8'h3C; start = 1'b1; abort = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_time = 5'd0; cfg_func = 3'd3;
    push_run(8'h5A, 8'h3C);
    push_idle(1);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); k++;
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL start_with_abort_cfg sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_hold_start();
    int k = 0;
    pulse_start(8'hC3, 8'h81);
    push_run(8'hC3, 8'h81);
    push_idle(7);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL hold_start sample %0d: got %h expected %h", k, o, e);
      end
      cfg_we = (k <= 13); cfg_idx = 2'd1; cfg_time = 5'd7; cfg_func = 3'd5;
    end
    cfg_we = 1'b0; start = 1'b0;
    pulse_start(8'h12, 8'h34);
    push_run(8'h12, 8'h34);
    push_idle(1);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); k++; start = 1'b0;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL table_stable sample %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int k = 0;
    write_cfg(0, 2, 6); m_time[0] = 5'd2; m_func[0] = 3'd6;
    pulse_start(8'hA5, 8'h0F);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'b001, 2'd0, ref_alu(m_func[0], 8'hA5, 8'h0F)));
    push_idle(1);
    model_default();
    push_run(8'hA5, 8'h0F);
    push_idle(1);
    while (exp_q.size() != 0) begin
      @(negedge clk); k++;
      e = exp_q.pop_front();
      o = {ready, busy, done, op_onehot, op_idx, dout};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_run sample %0d: got %h expected %h", k, o, e);
      end
      rst = (k == 1);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_time = '0; cfg_func = '0; din1 = '0; din2 = '0;
    test_reset();
    test_default_run();
    test_program();
    test_all_zero();
    do_reset();
    test_abort();
    test_back_to_back();
    test_hold_start();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
